// File: rtl/gmii_mac_tx.sv
// gmii_mac_tx: GMII transmit framer. Turns a valid/ready byte stream into
// preamble + SFD + payload (+ optional zero pad) + CRC-32 FCS, then holds
// TX_EN low for the inter-frame gap. A gap in s_valid mid-frame aborts the
// frame with a TX_ER cycle and discards the rest of the upstream frame.
// Optional feature: define MAC_TX_PAD_EN to pad short frames to MIN_FRAME.
module gmii_mac_tx #(
  parameter int IFG_BYTES = 12,
  parameter int MIN_FRAME = 60
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] s_data,
  input  logic       s_valid,
  input  logic       s_last,
  input  logic       s_err,
  output logic       s_ready,
  output logic [7:0] TXD,
  output logic       TX_EN,
  output logic       TX_ER,
  output logic       busy,
  output logic       frame_done
);

  typedef enum logic [2:0] {IDLE, PRE, SFD, DATA, PAD, FCS, DRAIN, IFG} state_t;

  localparam logic [7:0] IFG_LAST = 8'(IFG_BYTES);
`ifdef MAC_TX_PAD_EN
  localparam logic [15:0] MIN_LEN = 16'(MIN_FRAME);
`else
  // Without padding the minimum length has no effect.
  logic min_frame_unused;
  assign min_frame_unused = (MIN_FRAME > 0);
`endif

  state_t      state, state_n;
  logic [7:0]  cnt, cnt_n;
  logic [15:0] byte_cnt, byte_cnt_n;
  logic [31:0] crc, crc_n, fcs_word;
  logic [7:0]  txd_n;
  logic        en_n, er_n, done_n;

  // One byte of the reflected CRC-32 (poly 0xEDB88320), LSB first.
  function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'h000000, d};
    for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  // Frame byte counter sticks at its maximum instead of wrapping.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign s_ready  = (state == SFD) || (state == DATA) || (state == DRAIN);
  assign busy     = (state != IDLE);
  assign fcs_word = ~crc;

  // Next state and the GMII values to be registered for the following cycle.
  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    byte_cnt_n = byte_cnt;
    crc_n      = crc;
    txd_n      = 8'h00;
    en_n       = 1'b0;
    er_n       = 1'b0;
    done_n     = 1'b0;
    case (state)
      IDLE: begin
        if (s_valid) begin
          state_n    = PRE;
          cnt_n      = 8'd0;
          byte_cnt_n = 16'd0;
          crc_n      = 32'hFFFFFFFF;
          txd_n      = 8'h55;
          en_n       = 1'b1;
        end
      end
      PRE: begin
        en_n = 1'b1;
        // The IDLE cycle already launched the first preamble byte.
        if (cnt == 8'd6) begin
          txd_n   = 8'hD5;
          state_n = SFD;
        end else begin
          txd_n = 8'h55;
          cnt_n = cnt + 8'd1;
        end
      end
      SFD, DATA: begin
        en_n = 1'b1;
        if (s_valid) begin
          txd_n      = s_data;
          er_n       = s_err;
          crc_n      = crc_step(crc, s_data);
          byte_cnt_n = sat_inc16(byte_cnt);
          state_n    = DATA;
          if (s_last) begin
            cnt_n   = 8'd0;
            state_n = FCS;
`ifdef MAC_TX_PAD_EN
            if (byte_cnt_n < MIN_LEN) state_n = PAD;
`endif
          end
        end else begin
          // Underrun: poison the wire and throw away the rest of the frame.
          er_n    = 1'b1;
          state_n = DRAIN;
        end
      end
`ifdef MAC_TX_PAD_EN
      PAD: begin
        en_n       = 1'b1;
        crc_n      = crc_step(crc, 8'h00);
        byte_cnt_n = sat_inc16(byte_cnt);
        if (byte_cnt_n >= MIN_LEN) state_n = FCS;
      end
`endif
      FCS: begin
        en_n  = 1'b1;
        txd_n = fcs_word[{cnt[1:0], 3'b000} +: 8];
        if (cnt == 8'd3) begin
          done_n  = 1'b1;
          cnt_n   = 8'd0;
          state_n = IFG;
        end else begin
          cnt_n = cnt + 8'd1;
        end
      end
      DRAIN: begin
        if (s_valid && s_last) begin
          cnt_n   = 8'd0;
          state_n = IFG;
        end
      end
      IFG: begin
        // The cycle that enters IDLE also shows TX_EN low, so the wire sees
        // IFG_BYTES idle cycles followed by the IDLE sampling cycle.
        if (cnt == IFG_LAST) state_n = IDLE;
        else                 cnt_n = cnt + 8'd1;
      end
      default: state_n = IDLE;
    endcase
  end

  // State, counters, CRC and the registered GMII outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      cnt        <= 8'd0;
      byte_cnt   <= 16'd0;
      crc        <= 32'hFFFFFFFF;
      TXD        <= 8'h00;
      TX_EN      <= 1'b0;
      TX_ER      <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      byte_cnt   <= byte_cnt_n;
      crc        <= crc_n;
      TXD        <= txd_n;
      TX_EN      <= en_n;
      TX_ER      <= er_n;
      frame_done <= done_n;
    end
  end

endmodule

// File: tb/tb_gmii_mac_tx.sv
// Bench for gmii_mac_tx: a per-cycle expected-output timeline built from
// frame-level rules (preamble, payload, pad, FCS, gap, abort), compared
// against the DUT on every negedge, plus literal checks of known frames.
module tb_gmii_mac_tx;
  localparam int IFG  = 12;
  localparam int MINF = 60;
  localparam int NC   = 32768;
`ifdef MAC_TX_PAD_EN
  localparam bit PAD = 1'b1;
`else
  localparam bit PAD = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] s_data = 8'h00;
  logic       s_valid = 1'b0;
  logic       s_last = 1'b0;
  logic       s_err = 1'b0;
  logic       s_ready;
  logic [7:0] TXD;
  logic       TX_EN, TX_ER, busy, frame_done;

  gmii_mac_tx #(.IFG_BYTES(IFG), .MIN_FRAME(MINF)) dut (
    .clk(clk), .reset(reset), .s_data(s_data), .s_valid(s_valid),
    .s_last(s_last), .s_err(s_err), .s_ready(s_ready), .TXD(TXD),
    .TX_EN(TX_EN), .TX_ER(TX_ER), .busy(busy), .frame_done(frame_done)
  );

  always #4 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  bit [7:0] e_txd [NC];
  bit       e_en [NC], e_er [NC], e_done [NC], e_rdy [NC], e_busy [NC];
  bit [7:0] a_txd [NC];
  bit       a_en [NC], a_er [NC], a_done [NC];
  int       total = 0;
  int       bad = 0;
  bit       chk_on = 1'b0;
  int       free_at = 0;
  byte unsigned pay[$];

  // Per-cycle comparison against the expected timeline, plus capture.
  always @(negedge clk) begin
    if (chk_on && cyc < NC) begin
      a_txd[cyc]  = TXD;
      a_en[cyc]   = TX_EN;
      a_er[cyc]   = TX_ER;
      a_done[cyc] = frame_done;
      total++;
      if ({TXD, TX_EN, TX_ER, frame_done, s_ready, busy} !==
          {e_txd[cyc], e_en[cyc], e_er[cyc], e_done[cyc], e_rdy[cyc], e_busy[cyc]}) begin
        bad++;
        $display("FAIL cycle %0d: got txd=%h en=%b er=%b done=%b rdy=%b busy=%b, want txd=%h en=%b er=%b done=%b rdy=%b busy=%b",
                 cyc, TXD, TX_EN, TX_ER, frame_done, s_ready, busy,
                 e_txd[cyc], e_en[cyc], e_er[cyc], e_done[cyc], e_rdy[cyc], e_busy[cyc]);
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  function automatic bit [31:0] fcs32(input byte unsigned q[$]);
    bit [31:0] c;
    c = 32'hFFFFFFFF;
    foreach (q[i]) begin
      c = c ^ {24'h0, q[i]};
      for (int b = 0; b < 8; b++) c = (c >> 1) ^ (c[0] ? 32'hEDB88320 : 32'h0);
    end
    return ~c;
  endfunction

  function automatic void put(input int c, input bit [7:0] d, input bit er, input bit done);
    e_txd[c] = d; e_en[c] = 1'b1; e_er[c] = er; e_done[c] = done;
  endfunction

  function automatic void span(input int r0, input int r1, input int b0, input int b1);
    for (int c = r0; c <= r1; c++) e_rdy[c] = 1'b1;
    for (int c = b0; c <= b1; c++) e_busy[c] = 1'b1;
  endfunction

  // Length of the first TX_EN run at or after cycle s (captured data).
  function automatic int run_from(input int s, output int first);
    int c;
    c = s;
    while (c < s + 400 && !a_en[c]) c++;
    first = c;
    while (c < NC - 1 && a_en[c]) c++;
    return c - first;
  endfunction

  task automatic fill_rand(input int len);
    pay = {};
    for (int i = 0; i < len; i++) pay.push_back(8'($urandom_range(0, 255)));
  endtask

  // Build the expected timeline for one frame from pay[], then drive it.
  task automatic send_frame(input int len, input int err_at, input int ur_at,
                            input int rst_at, input int gap, output int n0);
    byte unsigned p[$];
    bit [31:0] fcs;
    int n, lp, endc;
    for (int g = 0; g < gap; g++) begin s_valid = 1'b0; next_cycle(); end
    n = (cyc > free_at) ? cyc : free_at;
    n0 = n;
    for (int k = 1; k <= 7; k++) put(n + k, 8'h55, 1'b0, 1'b0);
    put(n + 8, 8'hD5, 1'b0, 1'b0);
    if (ur_at >= 0) begin
      for (int i = 0; i < ur_at; i++) put(n + 9 + i, pay[i], i == err_at, 1'b0);
      put(n + 9 + ur_at, 8'h00, 1'b1, 1'b0);
      endc = n + 8 + len;
      span(n + 8, endc, n + 1, endc + IFG + 1);
      free_at = endc + IFG + 2;
    end else if (rst_at >= 0) begin
      for (int i = 0; i < rst_at; i++) put(n + 9 + i, pay[i], i == err_at, 1'b0);
      span(n + 8, n + 8 + rst_at, n + 1, n + 8 + rst_at);
      free_at = n + 10 + rst_at;
    end else begin
      p = pay;
      if (PAD) while (p.size() < MINF) p.push_back(8'h00);
      lp = p.size();
      fcs = fcs32(p);
      for (int i = 0; i < lp; i++) put(n + 9 + i, p[i], i == err_at, 1'b0);
      for (int b = 0; b < 4; b++) put(n + 9 + lp + b, fcs[8*b +: 8], 1'b0, b == 3);
      endc = n + 12 + lp;
      span(n + 8, n + 7 + len, n + 1, endc + IFG);
      free_at = endc + IFG + 1;
    end
    s_valid = 1'b1; s_data = pay[0]; s_last = (len == 1); s_err = (err_at == 0);
    while (cyc < n + 8) next_cycle();
    for (int i = 0; i < len; i++) begin
      if (i == ur_at) begin s_valid = 1'b0; next_cycle(); s_valid = 1'b1; end
      s_data = pay[i]; s_last = (i == len - 1); s_err = (i == err_at);
      if (i == rst_at) begin
        reset = 1'b0;
        next_cycle();
        s_valid = 1'b0; s_last = 1'b0; s_err = 1'b0;
        next_cycle();
        reset = 1'b1;
        return;
      end
      next_cycle();
    end
    s_valid = 1'b0; s_last = 1'b0; s_err = 1'b0;
  endtask

  task automatic settle();
    while (cyc < free_at + 2) next_cycle();
  endtask

  initial begin
    int n, n2, first, first2, len, zeros, err_at, ur_at;
    byte unsigned ref_q[$];
    bit [31:0] f;

    reset = 1'b0;
    repeat (3) next_cycle();
    chk_on = 1'b1;
    repeat (2) next_cycle();
    reset = 1'b1;
    free_at = cyc;

    ref_q = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    chk("model_crc_check", fcs32(ref_q), 32'hCBF43926);

`ifdef MAC_TX_PAD_EN
    pay = {}; pay.push_back(8'hAA);
    send_frame(1, -1, -1, -1, 2, n);
    settle();
    len = run_from(n, first);
    chk("pad_en_cycles", len, 72);
    chk("pad_first_byte", a_txd[first + 8], 8'hAA);
    zeros = 0;
    for (int i = 9; i < 68; i++) if (a_txd[first + i] == 8'h00) zeros++;
    chk("pad_zero_bytes", zeros, 59);
    ref_q = {}; ref_q.push_back(8'hAA);
    for (int i = 0; i < 59; i++) ref_q.push_back(8'h00);
    f = fcs32(ref_q);
    for (int b = 0; b < 4; b++) chk("pad_fcs_byte", a_txd[first + 68 + b], f[8*b +: 8]);
    chk("pad_frame_done", a_done[first + 71], 1);
`else
    pay = ref_q;
    send_frame(9, -1, -1, -1, 2, n);
    settle();
    len = run_from(n, first);
    chk("ascii_en_cycles", len, 21);
    chk("ascii_fcs0", a_txd[first + 17], 8'h26);
    chk("ascii_fcs1", a_txd[first + 18], 8'h39);
    chk("ascii_fcs2", a_txd[first + 19], 8'hF4);
    chk("ascii_fcs3", a_txd[first + 20], 8'hCB);
    chk("ascii_frame_done", a_done[first + 20], 1);
`endif

    // Back-to-back 64-byte frames with s_valid held high.
    fill_rand(64);
    send_frame(64, -1, -1, -1, 0, n);
    fill_rand(64);
    send_frame(64, -1, -1, -1, 0, n2);
    settle();
    len = run_from(n, first);
    chk("b2b_len", len, 76);
    void'(run_from(first + len, first2));
    chk("b2b_gap", first2 - (first + len), 13);

    // Underrun after byte 10 of a 100-byte frame.
    fill_rand(100);
    send_frame(100, -1, 10, -1, 3, n);
    settle();
    len = run_from(n, first);
    chk("underrun_en_cycles", len, 19);
    chk("underrun_er", a_er[first + 18], 1);

    // Error flag on byte 20 of a 64-byte frame.
    fill_rand(64);
    send_frame(64, 20, -1, -1, 2, n);
    settle();
    len = run_from(n, first);
    chk("err_len", len, 76);
    chk("err_flag_byte20", a_er[first + 28], 1);

    // Reset during byte 30, then a clean frame.
    fill_rand(64);
    send_frame(64, -1, -1, 30, 2, n);
    fill_rand(64);
    send_frame(64, -1, -1, -1, 1, n);
    settle();
    len = run_from(n, first);
    chk("post_reset_len", len, 76);

    // Randomized frames.
    for (int t = 0; t < 25; t++) begin
      len = $urandom_range(1, 130);
      err_at = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, len - 1)) : -1;
      ur_at  = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, len - 1)) : -1;
      fill_rand(len);
      send_frame(len, err_at, ur_at, -1, $urandom_range(0, 15), n);
    end
    settle();
    repeat (3) next_cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gmii_mac_tx.md
# gmii_mac_tx

MAC-side GMII transmit framer driving the `TXD`/`TX_EN`/`TX_ER` inputs of the 1000BASE-X PCS transmit path. It turns a byte stream with a valid/ready handshake into a complete Ethernet frame on the wire:
- preamble and SFD;
- payload, padded to the minimum length;
- CRC-32 FCS;
- enforced inter-frame gap.

Full-duplex only; `COL` is not consumed.

## Interface
- `IFG_BYTES`, default 12: idle cycles (`TX_EN`=0) between the last FCS byte and the next preamble; legal range 1..255.
- `MIN_FRAME`, default 60: minimum frame length in bytes, destination address through pad, excluding FCS.
- `clk` input 1: GMII transmit clock (125 MHz).
- `reset` input 1: synchronous, active-low.
- `s_data` input 8: payload byte (destination MAC first).
- `s_valid` input 1: `s_data` valid.
- `s_last` input 1: current beat is the last byte of the frame.
- `s_err` input 1: current beat is corrupt; propagate as `TX_ER`.
- `s_ready` output 1: byte accepted this cycle when `s_valid && s_ready`.
- `TXD` output 8: GMII data to PCS.
- `TX_EN` output 1: GMII transmit enable.
- `TX_ER` output 1: GMII transmit error.
- `busy` output 1: high in every state except IDLE.
- `frame_done` output 1: one-cycle pulse on the cycle the last FCS byte is on `TXD`.

## Operation
- States: IDLE, PRE, SFD, DATA, PAD, FCS, DRAIN, IFG.
- IDLE:
  - `s_valid`=1 → PRE.
  - `s_ready`=0; no byte is consumed in IDLE.
- PRE: 7 cycles of 0x55, then SFD.
- SFD: one cycle of 0xD5; `s_ready`=1 in this cycle.
- DATA:
  - `s_ready`=1.
  - Each accepted byte is sent on the following cycle.
  - Accepted `s_last` → PAD if the byte count is below `MIN_FRAME`, otherwise → FCS.
- PAD: 0x00 bytes until the byte count equals `MIN_FRAME`, then FCS.
- FCS:
  - 4 bytes of the inverted CRC, LSB byte first.
  - CRC-32 uses reflected polynomial 0xEDB88320, initial value 0xFFFFFFFF, and covers every data and pad byte.
- Underrun (`s_valid`=0 while `s_ready`=1 in DATA, or in SFD):
  - Drive `TXD`=0x00, `TX_EN`=1, `TX_ER`=1 for one cycle.
  - No FCS is sent.
  - If `s_last` has not yet been accepted → DRAIN, otherwise → IFG.
- `s_err`=1 on an accepted beat: that byte goes out with `TX_ER`=1. The frame continues normally, including FCS over the data as sent.
- DRAIN:
  - `TX_EN`=0, `s_ready`=1.
  - Beats are discarded until `s_last` is accepted, then → IFG.
  - IFG counting starts on DRAIN exit.
- IFG: `TX_EN`=0 for `IFG_BYTES` cycles, then IDLE. `s_ready`=0.
- Byte counter:
  - 16 bits, saturating at 0xFFFF.
  - No maximum-length check; oversize frames pass through.
- Reset values:
  - `TXD`=0x00, `TX_EN`=0, `TX_ER`=0.
  - `s_ready`=0, `busy`=0, `frame_done`=0.
  - State IDLE; CRC 0xFFFFFFFF.

## Timing
- `TXD`, `TX_EN`, `TX_ER` and `frame_done` are registered.
- `s_ready` is decoded from state.
- `s_valid` sampled high in IDLE at cycle N:
  - 0x55 on `TXD` at N+1..N+7.
  - 0xD5 at N+8.
  - First payload byte at N+9.
- Byte accepted at cycle k appears on `TXD` at k+1.
- `s_ready` falls in the cycle after the `s_last` beat is accepted.
- A frame of L ≥ `MIN_FRAME` bytes holds `TX_EN` high for 8+L+4 contiguous cycles.
- Earliest next-frame preamble: `IFG_BYTES`+1 cycles after the last FCS byte, i.e. one IDLE sampling cycle.
- `reset` low mid-frame: all outputs return to reset values on the next edge and the frame is truncated. The upstream is responsible for flushing its partial frame.

## Configuration
- `MAC_TX_PAD_EN` defined:
  - PAD state is present.
  - Frames shorter than `MIN_FRAME` are zero-padded before FCS.
- `MAC_TX_PAD_EN` undefined:
  - PAD state is not compiled.
  - FCS follows the last payload byte directly.
  - `MIN_FRAME` is ignored.

## Test plan
- Pad undefined, payload ASCII "123456789":
  - `TX_EN` high 21 cycles: 7×0x55, 0xD5, 9 payload bytes.
  - FCS bytes 0x26, 0x39, 0xF4, 0xCB; `frame_done` on the final byte.
- `MAC_TX_PAD_EN` defined, single payload byte 0xAA:
  - 0xAA then 59×0x00, then FCS matching a software CRC-32 over those 60 bytes.
  - `TX_EN` high 72 cycles.
- Two back-to-back 64-byte frames, `s_valid` held high:
  - Exactly 12 cycles of `TX_EN`=0 between the last FCS byte and the next 0x55, plus the one IDLE sampling cycle (13 total).
- `s_valid` dropped for one cycle after byte 10 of a 100-byte frame:
  - One cycle of `TX_EN`=1, `TX_ER`=1, `TXD`=0x00; no FCS; `TX_EN` low after.
  - Remaining 90 bytes drained with `s_ready`=1.
  - IFG starts after `s_last`.
- `s_err`=1 on byte 20 of a 64-byte frame: `TX_ER`=1 on exactly that output cycle; frame length and FCS otherwise normal.
- `reset`=0 during payload byte 30: next cycle `TX_EN`=0, `TX_ER`=0, `s_ready`=0, `busy`=0. A new frame after release starts with a clean preamble and correct FCS.
